// File: rtl/router_pkg.sv
// Shared defaults, stored-entry layout and width helpers for the router packet FIFO.
package router_pkg;

  localparam int DEF_DATA_W  = 8;
  localparam int DEF_LEN_LSB = 2;

  typedef struct packed {
    logic                  hdr;
    logic [DEF_DATA_W-1:0] data;
  } entry_t;

  function automatic int addr_w(input int depth);
    return $clog2(depth);
  endfunction

  function automatic int len_w(input int data_w, input int len_lsb);
    return data_w - len_lsb;
  endfunction

endpackage

// File: rtl/router_fifo_mem.sv
// Entry storage: synchronous write port and a registered, enabled read port.
module router_fifo_mem #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              clr_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W:0]   wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W:0]   rdata_o
);

  logic [DATA_W:0] mem_q [DEPTH];
  logic [DATA_W:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  // Clearing the read register keeps stale memory contents off the output after a flush.
  always_ff @(posedge clk) begin
    if (clr_i)     rdata_q <= '0;
    else if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/router_pkt_fifo.sv
// Packet-aware router channel FIFO: header-tagged entries, fill flags, overflow and
// read-side packet boundary tracking (last word / truncated packet).
module router_pkt_fifo
  import router_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int DEPTH     = 16,
  parameter int AF_THRESH = 14,
  parameter int LEN_LSB   = DEF_LEN_LSB
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   soft_rst,
  input  logic                   wr_en,
  input  logic                   rd_en,
  input  logic                   lfd_state,
  input  logic [DATA_W-1:0]      d_in,
  output logic [DATA_W-1:0]      dout,
  output logic                   dout_valid,
  output logic                   dout_hdr,
  output logic                   pkt_last,
  output logic                   pkt_err,
  output logic                   full,
  output logic                   empty,
  output logic                   almost_full,
  output logic [$clog2(DEPTH):0] level,
  output logic                   ovf
);

  localparam int ADDR_W = addr_w(DEPTH);
  localparam int PTR_W  = ADDR_W + 1;
  localparam int LEN_W  = len_w(DATA_W, LEN_LSB);
  localparam int CNT_W  = LEN_W + 1;

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, level_q, level_d;
  logic             full_q, full_d, empty_q, empty_d, af_q, af_d;
  logic             ovf_q, ovf_d, vld_q, vld_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             flush, wr_acc, rd_acc, is_hdr, last_c, err_c;
  logic [DATA_W:0]  rd_entry;
  logic [LEN_W-1:0] len;

  assign flush  = rst | soft_rst;
  assign wr_acc = wr_en & ~full_q & ~flush;
  assign rd_acc = rd_en & ~empty_q & ~flush;

  router_fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk     (clk),
    .clr_i   (flush),
    .we_i    (wr_acc),
    .waddr_i (wr_ptr_q[ADDR_W-1:0]),
    .wdata_i ({lfd_state, d_in}),
    .re_i    (rd_acc),
    .raddr_i (rd_ptr_q[ADDR_W-1:0]),
    .rdata_o (rd_entry)
  );

  assign is_hdr = rd_entry[DATA_W];
  assign len    = rd_entry[DATA_W-1:LEN_LSB];

  always_comb begin
    wr_ptr_d = wr_ptr_q + PTR_W'(wr_acc);
    rd_ptr_d = rd_ptr_q + PTR_W'(rd_acc);
    level_d  = wr_ptr_d - rd_ptr_d;
    empty_d  = (wr_ptr_d == rd_ptr_d);
    full_d   = (wr_ptr_d[ADDR_W] != rd_ptr_d[ADDR_W]) &&
               (wr_ptr_d[ADDR_W-1:0] == rd_ptr_d[ADDR_W-1:0]);
    af_d     = (level_d >= PTR_W'(AF_THRESH));
    ovf_d    = ovf_q | (wr_en & full_q);
    vld_d    = rd_acc;
  end

  // The counter is advanced while the word sits on dout, since the read port is registered.
  always_comb begin
    cnt_d  = cnt_q;
    last_c = 1'b0;
    err_c  = 1'b0;
    if (vld_q) begin
      if (is_hdr) begin
        err_c = (cnt_q != '0);
        cnt_d = {1'b0, len} + CNT_W'(1);
      end else if (cnt_q != '0) begin
        cnt_d  = cnt_q - CNT_W'(1);
        last_c = (cnt_q == CNT_W'(1));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
      af_q     <= 1'b0;
      ovf_q    <= 1'b0;
      vld_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      empty_q  <= empty_d;
      full_q   <= full_d;
      af_q     <= af_d;
      ovf_q    <= ovf_d;
      vld_q    <= vld_d;
      cnt_q    <= cnt_d;
    end
  end

  assign dout        = rd_entry[DATA_W-1:0];
  assign dout_valid  = vld_q;
  assign dout_hdr    = vld_q & is_hdr;
  assign pkt_last    = last_c;
  assign pkt_err     = err_c;
  assign full        = full_q;
  assign empty       = empty_q;
  assign almost_full = af_q;
  assign level       = level_q;
  assign ovf         = ovf_q;

endmodule

// File: tb/tb_router_pkt_fifo.sv
// Randomised and directed bench for router_pkt_fifo against a queue-based packet model.
module tb_router_pkt_fifo;
  import router_pkg::*;

  localparam int DATA_W  = 8;
  localparam int DEPTH   = 16;
  localparam int AF      = 14;
  localparam int LEN_LSB = 2;

  logic              clk = 1'b0;
  logic              rst, soft_rst, wr_en, rd_en, lfd_state;
  logic [DATA_W-1:0] d_in, dout;
  logic              dout_valid, dout_hdr, pkt_last, pkt_err;
  logic              full, empty, almost_full, ovf;
  logic [4:0]        level;

  router_pkt_fifo #(
    .DATA_W    (DATA_W),
    .DEPTH     (DEPTH),
    .AF_THRESH (AF),
    .LEN_LSB   (LEN_LSB)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .soft_rst    (soft_rst),
    .wr_en       (wr_en),
    .rd_en       (rd_en),
    .lfd_state   (lfd_state),
    .d_in        (d_in),
    .dout        (dout),
    .dout_valid  (dout_valid),
    .dout_hdr    (dout_hdr),
    .pkt_last    (pkt_last),
    .pkt_err     (pkt_err),
    .full        (full),
    .empty       (empty),
    .almost_full (almost_full),
    .level       (level),
    .ovf         (ovf)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  entry_t      q[$];
  bit          m_ovf, m_vld, m_hdr, m_last, m_err;
  logic [7:0]  m_dout;
  int          m_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // One clock of the channel at word/packet level.
  task automatic model(input bit r, input bit sr, input bit w, input bit rd,
                       input bit lfd, input logic [7:0] d);
    entry_t e;
    bit     was_full;
    if (r || sr) begin
      q.delete();
      m_ovf = 0; m_vld = 0; m_hdr = 0; m_last = 0; m_err = 0;
      m_dout = '0; m_cnt = 0;
      return;
    end
    was_full = (q.size() == DEPTH);
    m_vld = 0; m_hdr = 0; m_last = 0; m_err = 0;
    if (rd && q.size() != 0) begin
      e      = q.pop_front();
      m_vld  = 1;
      m_dout = e.data;
      m_hdr  = e.hdr;
      if (e.hdr) begin
        m_err = (m_cnt != 0);
        m_cnt = int'(e.data >> LEN_LSB) + 1;
      end else if (m_cnt > 0) begin
        m_cnt--;
        m_last = (m_cnt == 0);
      end
    end
    if (w) begin
      if (was_full) m_ovf = 1;
      else begin
        e.hdr  = lfd;
        e.data = d;
        q.push_back(e);
      end
    end
  endtask

  task automatic compare();
    int lv;
    lv = q.size();
    chk("level", 32'(level),       32'(lv));
    chk("empty", 32'(empty),       32'(lv == 0));
    chk("full",  32'(full),        32'(lv == DEPTH));
    chk("afull", 32'(almost_full), 32'(lv >= AF));
    chk("ovf",   32'(ovf),         32'(m_ovf));
    chk("vld",   32'(dout_valid),  32'(m_vld));
    chk("dout",  32'(dout),        32'(m_dout));
    chk("hdr",   32'(dout_hdr),    32'(m_hdr));
    chk("last",  32'(pkt_last),    32'(m_last));
    chk("err",   32'(pkt_err),     32'(m_err));
  endtask

  task automatic step(input bit r, input bit sr, input bit w, input bit rd,
                      input bit lfd, input logic [7:0] d);
    rst = r; soft_rst = sr; wr_en = w; rd_en = rd; lfd_state = lfd; d_in = d;
    @(posedge clk);
    model(r, sr, w, rd, lfd, d);
    #1;
    compare();
  endtask

  task automatic wr(input bit lfd, input logic [7:0] d);
    step(0, 0, 1, 0, lfd, d);
  endtask

  task automatic rd_n(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 1, 0, 8'h00);
  endtask

  initial begin
    step(1, 0, 0, 0, 0, 8'h00);
    step(1, 0, 0, 0, 0, 8'h00);

    // hard reset mid-traffic at level 5, with wr/rd in the reset cycle
    for (int i = 0; i < 5; i++) wr(0, 8'(8'h30 + i));
    rd_n(1);
    wr(0, 8'h3A);
    step(1, 0, 1, 1, 0, 8'hEE);
    step(0, 0, 0, 1, 0, 8'h00);

    // complete packet: header len=3, 3 payload + parity
    wr(1, 8'h0C);
    for (int i = 0; i < 4; i++) wr(0, 8'(8'hA0 + i));
    rd_n(6);

    // fill past full, then read/write at full, then wrap at level 8
    for (int i = 0; i < 17; i++) wr(0, 8'(i));
    step(0, 0, 1, 1, 0, 8'h77);
    rd_n(7);
    for (int i = 0; i < 12; i++) step(0, 0, 1, 1, 0, 8'(8'hC0 + i));
    rd_n(10);

    // truncated packet followed by a len=0 packet
    wr(1, 8'h0C); wr(0, 8'h11); wr(0, 8'h22);
    wr(1, 8'h00); wr(0, 8'h33);
    rd_n(6);

    // soft reset at level 6 while writing
    for (int i = 0; i < 6; i++) wr(0, 8'(8'h50 + i));
    step(0, 1, 1, 0, 0, 8'h99);
    wr(0, 8'h5A);
    rd_n(2);

    // random traffic in alternating fill/drain phases
    for (int i = 0; i < 4000; i++) begin
      bit r, sr, w, rdb, lfd;
      int wp;
      wp  = ((i / 250) % 2 == 0) ? 75 : 30;
      r   = ($urandom_range(0, 399) == 0);
      sr  = ($urandom_range(0, 149) == 0);
      w   = ($urandom_range(0, 99) < wp);
      rdb = ($urandom_range(0, 99) < (105 - wp));
      lfd = ($urandom_range(0, 4) == 0);
      step(r, sr, w, rdb, lfd, 8'($urandom_range(0, 255)));
    end
    rd_n(DEPTH + 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
